// File: rtl/deskew_fifo_rx.sv
// Multi-lane receive deskew: each lane buffers {am, block} in a ring; alignment
// markers set per-lane read pointers so that all lanes emit equal-index blocks.
module deskew_fifo_rx #(
  parameter int LANE_N   = 4,
  parameter int BLOCK_W  = 66,
  parameter int SKEW_MAX = 27,
  parameter int DEPTH    = SKEW_MAX + 2,
  parameter int SKEW_W   = $clog2(SKEW_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANE_N-1:0]         valid_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      valid_o,
  output logic                      am_v_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic [LANE_N*SKEW_W-1:0]  skew_o,
  output logic                      locked_o,
  output logic                      skew_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (SKEW_MAX > 0) ? $clog2(SKEW_MAX + 1) : 1;

  typedef enum logic [0:0] {ST_ALIGN, ST_LOCKED} state_e;
  typedef logic [BLOCK_W:0]   ent_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [BLOCK_W-1:0] blk_t;

  state_e                    state_q, state_d;
  ptr_t                      wp_q, wp_d;
  ptr_t                      rp_q [LANE_N];
  ptr_t                      rp_d [LANE_N];
  ptr_t                      mk_q [LANE_N];
  ptr_t                      mk_d [LANE_N];
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      win_q, win_d;
  logic [LANE_N-1:0]         cap_q, cap_d;
  logic [SKEW_W-1:0]         cskew_q [LANE_N];
  logic [SKEW_W-1:0]         cskew_d [LANE_N];
  logic [SKEW_W-1:0]         skew_q [LANE_N];
  logic [SKEW_W-1:0]         skew_d [LANE_N];
  logic                      valid_q, valid_d;
  logic                      am_q, am_d;
  logic                      err_q, err_d;
  logic [LANE_N*BLOCK_W-1:0] data_q, data_d;

  ent_t                      mem_q [LANE_N][DEPTH];
  ent_t                      in_ent [LANE_N];
  ent_t                      rd_ent [LANE_N];
  blk_t                      lk_dat [LANE_N];
  ptr_t                      rn [LANE_N];
  logic [LANE_N-1:0]         rd_am;
  logic [LANE_N-1:0]         new_cap;
  logic                      wr;
  logic                      fail;
  logic                      open_win;
  logic [CNT_W-1:0]          cnt_nx;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign wr = &valid_i;

  always_comb begin : read_side
    for (int unsigned l = 0; l < LANE_N; l++) begin
      in_ent[l] = {am_v_i[l], data_i[l*BLOCK_W +: BLOCK_W]};
      rn[l]     = ptr_inc(rp_q[l]);
      // The latest lane reads the very slot being written this cycle.
      rd_ent[l] = (rn[l] == wp_q) ? in_ent[l] : mem_q[l][rn[l]];
      rd_am[l]  = rd_ent[l][BLOCK_W];
      lk_dat[l] = new_cap[l] ? data_i[l*BLOCK_W +: BLOCK_W]
                             : mem_q[l][mk_q[l]][BLOCK_W-1:0];
    end
  end

  always_comb begin : capture
    open_win = 1'b0;
    fail     = 1'b0;
    new_cap  = '0;
    cnt_nx   = cnt_q;
    if (state_q == ST_ALIGN && wr) begin
      if (!win_q) begin
        open_win = |am_v_i;
        new_cap  = am_v_i;
        cnt_nx   = '0;
      end else begin
        cnt_nx  = cnt_q + CNT_W'(1);
        new_cap = am_v_i & ~cap_q;
        fail    = (|(am_v_i & cap_q)) ||
                  (cnt_nx == CNT_W'(SKEW_MAX) && (cap_q | new_cap) != '1);
        // A marker coinciding with a failure is discarded.
        if (fail) new_cap = '0;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    mk_d    = mk_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    cap_d   = cap_q;
    cskew_d = cskew_q;
    skew_d  = skew_q;
    valid_d = 1'b0;
    am_d    = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;

    if (wr) wp_d = ptr_inc(wp_q);

    case (state_q)
      ST_LOCKED: begin
        if (!wr) begin
          state_d = ST_ALIGN;
        end else if (rd_am != '0 && rd_am != '1) begin
          err_d   = 1'b1;
          state_d = ST_ALIGN;
        end else begin
          for (int unsigned l = 0; l < LANE_N; l++) begin
            rp_d[l] = rn[l];
            data_d[l*BLOCK_W +: BLOCK_W] = rd_ent[l][BLOCK_W-1:0];
          end
          valid_d = 1'b1;
          am_d    = &rd_am;
        end
      end
      ST_ALIGN: begin
        if (!wr) begin
          win_d = 1'b0;
          cap_d = '0;
        end else if (fail) begin
          err_d = 1'b1;
          win_d = 1'b0;
          cap_d = '0;
        end else if (win_q || open_win) begin
          win_d = 1'b1;
          cnt_d = cnt_nx;
          cap_d = cap_q | new_cap;
          for (int unsigned l = 0; l < LANE_N; l++) begin
            if (new_cap[l]) begin
              mk_d[l]    = wp_q;
              cskew_d[l] = SKEW_W'(cnt_nx);
            end
          end
          if (&(cap_q | new_cap)) begin
            state_d = ST_LOCKED;
            win_d   = 1'b0;
            cap_d   = '0;
            valid_d = 1'b1;
            am_d    = 1'b1;
            for (int unsigned l = 0; l < LANE_N; l++) begin
              rp_d[l]   = mk_d[l];
              skew_d[l] = cskew_d[l];
              data_d[l*BLOCK_W +: BLOCK_W] = lk_dat[l];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ALIGN;
      wp_q    <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      for (int unsigned l = 0; l < LANE_N; l++) begin
        rp_q[l]    <= '0;
        mk_q[l]    <= '0;
        cskew_q[l] <= '0;
        skew_q[l]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      mk_q    <= mk_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      cap_q   <= cap_d;
      cskew_q <= cskew_d;
      skew_q  <= skew_d;
      valid_q <= valid_d;
      am_q    <= am_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      for (int unsigned l = 0; l < LANE_N; l++) begin
        mem_q[l][wp_q] <= in_ent[l];
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANE_N; l++) begin
      skew_o[l*SKEW_W +: SKEW_W] = skew_q[l];
    end
  end

  assign valid_o    = valid_q;
  assign am_v_o     = am_q;
  assign data_o     = data_q;
  assign locked_o   = (state_q == ST_LOCKED);
  assign skew_err_o = err_q;

endmodule

// File: tb/tb_deskew_fifo_rx.sv
// Randomized scoreboard bench for deskew_fifo_rx against a write-history
// reference model (unbounded per-write record list indexed by write number).
module tb_deskew_fifo_rx;
  localparam int L  = 4;
  localparam int BW = 66;
  localparam int SM = 27;
  localparam int D  = SM + 2;
  localparam int SW = $clog2(SM + 1);

  typedef logic [L*BW-1:0] wide_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [L-1:0]  valid_i, am_v_i;
  wide_t         data_i;
  logic          valid_o, am_v_o, locked_o, skew_err_o;
  wide_t         data_o;
  logic [L*SW-1:0] skew_o;

  always #5 clk = ~clk;

  deskew_fifo_rx #(.LANE_N(L), .BLOCK_W(BW), .SKEW_MAX(SM), .DEPTH(D), .SKEW_W(SW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .am_v_i(am_v_i), .data_i(data_i),
    .valid_o(valid_o), .am_v_o(am_v_o), .data_o(data_o), .skew_o(skew_o),
    .locked_o(locked_o), .skew_err_o(skew_err_o)
  );

  typedef struct packed { logic [L-1:0] am; wide_t d; } wr_t;
  typedef struct {
    logic valid, am, locked, err, cmp_data;
    wide_t data;
    logic [L*SW-1:0] skew;
  } exp_t;

  wr_t  hist[$];
  exp_t exp_q[$];
  exp_t m_out;
  bit   m_locked, m_win;
  int   m_start;
  int   m_cap[L];
  int   m_rd[L];
  int   m_skew[L];
  int   n_chk = 0, n_fail = 0;
  int   s[L];
  int   per = 40;
  int   k = 0;

  task automatic chk(input string nm, input wide_t act, input wide_t expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [L-1:0] v,
                            input logic [L-1:0] am, input wide_t d);
    int idx;
    logic [L-1:0] ra;
    bit fl, all;
    wr_t e;
    m_out.err = 0; m_out.valid = 0; m_out.am = 0; m_out.cmp_data = 0;
    fl = 0; all = 0;
    if (rst) begin
      hist.delete();
      m_locked = 0; m_win = 0;
      for (int l = 0; l < L; l++) begin m_cap[l] = -1; m_skew[l] = 0; m_rd[l] = 0; end
      m_out.data = '0;
      m_out.cmp_data = 1;
    end else if (!(&v)) begin
      m_locked = 0; m_win = 0;
      for (int l = 0; l < L; l++) m_cap[l] = -1;
    end else begin
      hist.push_back('{am: am, d: d});
      idx = hist.size() - 1;
      if (m_locked) begin
        for (int l = 0; l < L; l++) begin
          m_rd[l]++;
          e = hist[m_rd[l]];
          ra[l] = e.am[l];
          m_out.data[l*BW +: BW] = e.d[l*BW +: BW];
        end
        if (ra != '0 && ra != '1) begin
          m_out.err = 1; m_locked = 0;
        end else begin
          m_out.valid = 1; m_out.am = &ra;
        end
      end else begin
        if (!m_win) begin
          if (am != '0) begin m_win = 1; m_start = idx; end
        end else begin
          for (int l = 0; l < L; l++) if (am[l] && m_cap[l] >= 0) fl = 1;
        end
        if (m_win && !fl) begin
          all = 1;
          for (int l = 0; l < L; l++) begin
            if (am[l] && m_cap[l] < 0) m_cap[l] = idx;
            if (m_cap[l] < 0) all = 0;
          end
          if (!all && idx - m_start == SM) fl = 1;
        end
        if (fl) begin
          m_out.err = 1; m_win = 0;
          for (int l = 0; l < L; l++) m_cap[l] = -1;
        end else if (m_win && all) begin
          m_locked = 1; m_win = 0;
          m_out.valid = 1; m_out.am = 1;
          for (int l = 0; l < L; l++) begin
            m_rd[l]   = m_cap[l];
            m_skew[l] = m_cap[l] - m_start;
            e = hist[m_cap[l]];
            m_out.data[l*BW +: BW] = e.d[l*BW +: BW];
            m_cap[l]  = -1;
          end
        end
      end
    end
    m_out.locked = m_locked;
    for (int l = 0; l < L; l++) m_out.skew[l*SW +: SW] = SW'(m_skew[l]);
  endtask

  task automatic step(input logic rst, input logic [L-1:0] v,
                      input logic [L-1:0] am, input wide_t d);
    reset = rst; valid_i = v; am_v_i = am; data_i = d;
    model_step(rst, v, am, d);
    @(posedge clk);
    exp_q.push_back(m_out);
    #1;
  endtask

  task automatic cyc(input logic rst, input int drop_pct, input logic [L-1:0] force_low);
    logic [L-1:0] v, am;
    wide_t d;
    logic [95:0] r;
    v = ~force_low;
    if ($urandom_range(99) < drop_pct) v[$urandom_range(L-1)] = 1'b0;
    am = '0;
    if (&v) begin
      for (int l = 0; l < L; l++) am[l] = (((k + 64*per - s[l]) % per) == 0);
      k++;
    end
    for (int l = 0; l < L; l++) begin
      r = {$urandom(), $urandom(), $urandom()};
      d[l*BW +: BW] = r[BW-1:0];
    end
    step(rst, v, am, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid_o",    wide_t'(valid_o),    wide_t'(e.valid));
      chk("am_v_o",     wide_t'(am_v_o),     wide_t'(e.am));
      chk("locked_o",   wide_t'(locked_o),   wide_t'(e.locked));
      chk("skew_err_o", wide_t'(skew_err_o), wide_t'(e.err));
      chk("skew_o",     wide_t'(skew_o),     wide_t'(e.skew));
      if (e.valid || e.cmp_data) chk("data_o", data_o, e.data);
    end
  end

  initial begin
    bit hit;
    reset = 1'b1; valid_i = '0; am_v_i = '0; data_i = '0;
    s = '{0, 0, 0, 0}; per = 40;
    repeat (3) cyc(1'b1, 0, '0);
    repeat (120) cyc(1'b0, 0, '0);              // all lanes aligned
    s = '{0, 3, 5, 27};
    repeat (200) cyc(1'b0, 0, '0);              // maximum tolerated skew
    s[2] = 6;
    repeat (160) cyc(1'b0, 0, '0);              // lane 2 marker slips one block
    s = '{0, 3, 5, 28};
    repeat (200) cyc(1'b0, 0, '0);              // skew beyond limit
    s = '{0, 3, 5, 27};
    repeat (150) cyc(1'b0, 0, '0);
    cyc(1'b0, 0, 4'b0010);                      // lane 1 loses valid once
    repeat (150) cyc(1'b0, 0, '0);
    for (int r = 0; r < 8; r++) begin
      per = (r % 2 == 1) ? 12 : 40;
      for (int l = 0; l < L; l++) s[l] = $urandom_range(30);
      repeat (200) cyc(1'b0, 2, '0);
    end
    s = '{0, 1, 2, 3}; per = 40;
    hit = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_locked && (hist.size() % D) == D - 1) begin hit = 1; break; end
      cyc(1'b0, 0, '0);
    end
    chk("locked_at_wp_last", wide_t'(hit), wide_t'(1));
    cyc(1'b1, 0, '0);                           // reset while locked, wp = DEPTH-1
    repeat (100) cyc(1'b0, 0, '0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drain", wide_t'(exp_q.size()), wide_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/deskew_fifo_rx.md
DESKEW_FIFO_RX -- requirements
Module: deskew_fifo_rx

Interface
REQ-001 Parameter LANE_N, default 4: number of PCS lanes.
REQ-002 Parameter BLOCK_W, default 66: block width in bits.
REQ-003 Parameter SKEW_MAX, default 27: max tolerated skew between lanes, in blocks.
REQ-004 Parameter DEPTH, default SKEW_MAX+2: per-lane buffer entries.
REQ-005 Parameter SKEW_W, default $clog2(SKEW_MAX+1): width of the per-lane skew report.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 valid_i  in  LANE_N  per-lane block valid (signal_ok and block lock).
REQ-009 am_v_i  in  LANE_N  per-lane alignment marker present on data_i this cycle.
REQ-010 data_i  in  LANE_N*BLOCK_W  lane l at [l*BLOCK_W +: BLOCK_W].
REQ-011 valid_o  out  1  deskewed output valid.
REQ-012 am_v_o  out  1  markers of all lanes present on data_o this cycle.
REQ-013 data_o  out  LANE_N*BLOCK_W  deskewed blocks, same lane packing as data_i.
REQ-014 skew_o  out  LANE_N*SKEW_W  per-lane skew in blocks, relative to earliest lane.
REQ-015 locked_o  out  1  FSM in LOCKED.
REQ-016 skew_err_o  out  1  one-cycle pulse on alignment failure.

Function
REQ-017 Write cycle = cycle with &valid_i; all other cycles SHALL leave all state unchanged except REQ-026.
REQ-018 Each lane SHALL own a DEPTH-entry circular buffer of {am bit, block}; a single shared write pointer wp SHALL write all lanes each write cycle, wrapping DEPTH-1 -> 0.
REQ-019 FSM states: ALIGN, LOCKED; reset state ALIGN.
REQ-020 ALIGN, window closed: first write cycle with any am_v_i bit set SHALL open the window, clear counter cnt to 0, and capture mk[l]=wp and skew[l]=0 for every lane with am_v_i[l].
REQ-021 ALIGN, window open: each later write cycle SHALL increment cnt, then capture mk[l]=wp and skew[l]=cnt for each uncaptured lane with am_v_i[l].
REQ-022 When the last lane is captured, FSM SHALL enter LOCKED and set rp[l]=mk[l]; the cycle after, valid_o=1, am_v_o=1, and lane l of data_o SHALL equal the block written at mk[l].
REQ-023 LOCKED: each write cycle SHALL advance every rp[l] by one, wrapping at DEPTH-1, and register the block at rp[l] onto data_o with valid_o=1 on the following cycle; am_v_o = AND of read-side am bits.
REQ-024 ALIGN failures, each SHALL pulse skew_err_o, close the window, clear captures, stay ALIGN: cnt reaching SKEW_MAX with a lane uncaptured; an already-captured lane asserting am_v_i again.
REQ-025 LOCKED failure: read-side am bits neither all 0 nor all 1 SHALL pulse skew_err_o, suppress that output (valid_o=0, am_v_o=0), go to ALIGN.
REQ-026 Any non-write cycle (some valid_i low) in LOCKED or with window open SHALL drop to ALIGN, close the window, drive valid_o=0; no skew_err_o pulse.
REQ-027 Simultaneous: a lane whose marker arrives in the same cycle as a failure condition SHALL NOT be captured; the failure takes priority.
REQ-028 skew_o SHALL hold the last successful capture values until the next successful lock; locked_o=1 exactly while in LOCKED.
REQ-029 valid_o and am_v_o SHALL be 0 in every cycle the FSM is not in LOCKED, except the first output cycle of REQ-022.

Reset
REQ-030 Reset SHALL set state ALIGN, wp=0, all rp/mk/cnt=0, window closed, captures clear, valid_o=0, am_v_o=0, locked_o=0, skew_err_o=0, skew_o=0, data_o=0.
REQ-031 Reset asserted mid-LOCKED SHALL take effect on the next edge and override all other events; buffer contents need not be cleared.

Verification
REQ-032 LANE_N=4, markers on all lanes same cycle -> lock; am_v_o=1 one cycle later; skew_o all 0.
REQ-033 Markers lanes 0,1,2,3 at write cycles t, t+3, t+5, t+27 -> skew_o={27,5,3,0}; every output cycle carries equal-index blocks; am_v_o every marker period.
REQ-034 Lane 3 marker at t+28 (beyond SKEW_MAX=27) -> skew_err_o pulse at t+27, locked_o stays 0, relock on next marker set.
REQ-035 Locked, then lane 2 marker shifted one block -> skew_err_o pulse, valid_o=0, returns to ALIGN, relocks with new skew_o[2].
REQ-036 Locked, valid_i[1] low for one cycle -> valid_o=0, locked_o=0, no skew_err_o; relock after next markers.
REQ-037 Reset pulse while locked at wp=DEPTH-1 -> all outputs 0 next cycle, wp=0.
